// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types, geometry constants and address helpers for data_mem.
// Geometry is fixed here. data_mem's XLEN/MEM_LEN parameters default to these values
// and must stay equal to them.
package data_mem_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int MEM_LEN_DEF = 256;

    localparam int BC    = XLEN_DEF / 8;          // bytes per word
    localparam int BADDR = $clog2(BC);            // byte-offset bits inside a word
    localparam int WADDR = $clog2(MEM_LEN_DEF);   // word-index bits

    typedef logic [BC-1:0][7:0]    word_t;
    typedef logic [XLEN_DEF-1:0]   addr_t;
    typedef logic [WADDR-1:0]      idx_t;

    // True when the byte address lands inside the array. Addresses past the top
    // must never alias onto low words, so the full address is compared.
    function automatic logic in_range(input addr_t addr);
        return addr < addr_t'(MEM_LEN_DEF * BC);
    endfunction

    // Word index. The low byte-offset bits are dropped because accesses are always full-word.
    function automatic idx_t word_idx(input addr_t addr);
        return addr[BADDR+WADDR-1:BADDR];
    endfunction

endpackage

// File: rtl/data_mem_addr_dec.sv
// data_mem_addr_dec: combinational byte-address decoder (word index + range flag).
module data_mem_addr_dec
    import data_mem_pkg::*;
(
    input  logic [XLEN_DEF-1:0] addr,
    output logic [WADDR-1:0]    idx,
    output logic                addr_ok
);

    // Split the byte address into a word index and an in-range flag.
    always_comb begin
        idx     = word_idx(addr);
        addr_ok = in_range(addr);
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: MEM_LEN x XLEN word memory. All state changes on the falling clock edge.
// Synchronous write; registered read (read-before-write); out-of-range error flag.
// Optional macro DATA_MEM_BYTE_WRITE_EN adds byte enables (be) and a clear-on-reset
// sequencer (init_busy).
module data_mem
    import data_mem_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int MEM_LEN = MEM_LEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic            rd,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data_in,
`ifdef DATA_MEM_BYTE_WRITE_EN
    input  logic [BC-1:0]   be,
    output logic            init_busy,
`endif
    output logic [XLEN-1:0] data_out,
    output logic            addr_err
);

    word_t            mem [MEM_LEN];
    word_t            data_out_q;
    word_t            wdata;
    logic             addr_err_q;
    logic             addr_err_d;
    logic [WADDR-1:0] idx;
    logic             addr_ok;
    logic             acc_gate;
    logic             acc_en;
    logic             wr_en;
    logic             rd_en;

    // Both the write path and the read path use this one decoded address.
    data_mem_addr_dec u_addr_dec (
        .addr    (addr),
        .idx     (idx),
        .addr_ok (addr_ok)
    );

    assign wdata    = data_in;
    assign data_out = data_out_q;
    assign addr_err = addr_err_q;

`ifdef DATA_MEM_BYTE_WRITE_EN
    logic             init_busy_q;
    logic             init_busy_d;
    logic [WADDR-1:0] init_ptr_q;
    logic [WADDR-1:0] init_ptr_d;
    logic [BC-1:0]    byte_we;

    // One write-enable per byte lane. With be == 0 no lane is written.
    for (genvar gi = 0; gi < BC; gi++) begin : g_byte_we
        assign byte_we[gi] = wr_en & be[gi];
    end

    // Clear sequencer next state: step the pointer upward and drop busy after the last word.
    always_comb begin
        init_busy_d = init_busy_q;
        init_ptr_d  = init_ptr_q;
        if (init_busy_q) begin
            if (init_ptr_q == WADDR'(MEM_LEN - 1)) begin
                init_busy_d = 1'b0;
            end else begin
                init_ptr_d = init_ptr_q + 1'b1;
            end
        end
    end

    // Clear sequencer registers. Reset restarts the clear from word 0.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            init_busy_q <= 1'b1;
            init_ptr_q  <= '0;
        end else begin
            init_busy_q <= init_busy_d;
            init_ptr_q  <= init_ptr_d;
        end
    end

    assign init_busy = init_busy_q;
    assign acc_gate  = ~init_busy_q;
`else
    assign acc_gate  = 1'b1;
`endif

    // Access qualification. The error flag follows every enabled access and holds otherwise.
    always_comb begin
        acc_en     = (we | rd) & acc_gate;
        wr_en      = we & addr_ok & acc_gate;
        rd_en      = rd & acc_gate;
        addr_err_d = addr_err_q;
        if (acc_en) begin
            addr_err_d = ~addr_ok;
        end
    end

    // Array write, registered read and error flag, all on the falling edge.
    // The read samples the array before this edge's write lands, which gives read-before-write.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
`ifdef DATA_MEM_BYTE_WRITE_EN
            if (init_busy_q) begin
                mem[init_ptr_q] <= '0;
            end else begin
                for (int b = 0; b < BC; b++) begin
                    if (byte_we[b]) begin
                        mem[idx][b] <= wdata[b];
                    end
                end
            end
`else
            if (wr_en) begin
                mem[idx] <= wdata;
            end
`endif
            if (rd_en) begin
                data_out_q <= addr_ok ? mem[idx] : '0;
            end
            addr_err_q <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem.
// Inputs change after the rising edge. Outputs are checked 1ns after the falling edge.
// Also covers DATA_MEM_BYTE_WRITE_EN when that macro is defined.
module tb_data_mem;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        addr_err;
`ifdef DATA_MEM_BYTE_WRITE_EN
    logic [3:0]  be;
    logic        init_busy;
`endif

    int n_checks;
    int n_fail;

    data_mem dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .rd       (rd),
        .addr     (addr),
        .data_in  (data_in),
`ifdef DATA_MEM_BYTE_WRITE_EN
        .be       (be),
        .init_busy(init_busy),
`endif
        .data_out (data_out),
        .addr_err (addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction. Drive after the rising edge and return 1ns after the falling edge.
    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        we      = w;
        rd      = r;
        addr    = a;
        data_in = d;
        @(negedge clk);
        #1;
        $display("txn rst_n=%b we=%b rd=%b addr=%h din=%h -> dout=%h err=%b",
                 rst_n, w, r, a, d, data_out, addr_err);
    endtask

`ifdef DATA_MEM_BYTE_WRITE_EN
    task automatic wait_init();
        int n;
        n = 0;
        while (init_busy !== 1'b0 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("init_done", 32'(init_busy), 32'd0);
    endtask
`endif

    initial begin
        logic [31:0] exp_after_rst;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        rd       = 1'b1;
        addr     = '0;
        data_in  = '0;
`ifdef DATA_MEM_BYTE_WRITE_EN
        be       = 4'hF;
`endif

        // 1 reset with rd=1 held for two edges
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        check_eq("rst_dout", data_out, 32'h0);
        check_eq("rst_err", 32'(addr_err), 32'h0);
        rst_n = 1'b1;
`ifdef DATA_MEM_BYTE_WRITE_EN
        wait_init();
`endif

        // 2 sequential fill and read-back
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 32'(i * 4), 32'(i));
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), 32'h0);
            check_eq("fill_rd", data_out, 32'(i));
        end

        // 3 read-before-write on word 2
        drive(1'b1, 1'b0, 32'd8, 32'hA5A5_A5A5);
        drive(1'b1, 1'b1, 32'd8, 32'h1234_5678);
        check_eq("rbw_old", data_out, 32'hA5A5_A5A5);
        drive(1'b0, 1'b1, 32'd8, 32'h0);
        check_eq("rbw_new", data_out, 32'h1234_5678);

        // 4 unaligned address ignores the byte offset; rd=0 holds data_out
        drive(1'b1, 1'b0, 32'h13, 32'hCAFE_BABE);
        drive(1'b0, 1'b1, 32'h10, 32'h0);
        check_eq("unal_rd", data_out, 32'hCAFE_BABE);
        check_eq("unal_err", 32'(addr_err), 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("hold_dout", data_out, 32'hCAFE_BABE);

        // 5 out-of-range accesses
        drive(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
        check_eq("oor_wr_err", 32'(addr_err), 32'h1);
        check_eq("oor_wr_dout", data_out, 32'hCAFE_BABE);
        drive(1'b0, 1'b0, 32'd0, 32'h0);
        check_eq("err_hold", 32'(addr_err), 32'h1);
        drive(1'b0, 1'b1, 32'd1024, 32'h0);
        check_eq("oor_rd_dout", data_out, 32'h0);
        check_eq("oor_rd_err", 32'(addr_err), 32'h1);
        drive(1'b0, 1'b1, 32'd0, 32'h0);
        check_eq("mem0_kept", data_out, 32'h0);
        check_eq("err_clear", 32'(addr_err), 32'h0);
        drive(1'b1, 1'b0, 32'h8000_0004, 32'h0000_0055);
        check_eq("alias_err", 32'(addr_err), 32'h1);
        drive(1'b0, 1'b1, 32'd4, 32'h0);
        check_eq("no_alias", data_out, 32'h1);
        drive(1'b1, 1'b0, 32'd1023, 32'hBEEF_0001);
        check_eq("top_wr_err", 32'(addr_err), 32'h0);
        drive(1'b0, 1'b1, 32'd1020, 32'h0);
        check_eq("top_rd", data_out, 32'hBEEF_0001);

`ifdef DATA_MEM_BYTE_WRITE_EN
        // 6 byte enables
        drive(1'b1, 1'b0, 32'd4, 32'h1122_3344);
        be = 4'b0101;
        drive(1'b1, 1'b0, 32'd4, 32'hAABB_CCDD);
        be = 4'hF;
        drive(1'b0, 1'b1, 32'd4, 32'h0);
        check_eq("be_0101", data_out, 32'h11BB_33DD);
        be = 4'b0000;
        drive(1'b1, 1'b0, 32'd4, 32'hFFFF_FFFF);
        be = 4'hF;
        drive(1'b0, 1'b1, 32'd4, 32'h0);
        check_eq("be_0000", data_out, 32'h11BB_33DD);
`endif

        // reset mid-operation: write suppressed, outputs forced to 0
        drive(1'b0, 1'b1, 32'd8, 32'h0);
        check_eq("pre_rst_rd", data_out, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'd2000, 32'h0000_0099);
        check_eq("pre_rst_err", 32'(addr_err), 32'h1);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 32'd12, 32'h0000_0077);
        check_eq("midrst_dout", data_out, 32'h0);
        check_eq("midrst_err", 32'(addr_err), 32'h0);
        rst_n = 1'b1;
`ifdef DATA_MEM_BYTE_WRITE_EN
        wait_init();
        exp_after_rst = 32'h0;
`else
        exp_after_rst = 32'h3;
`endif
        drive(1'b0, 1'b1, 32'd12, 32'h0);
        check_eq("midrst_nowr", data_out, exp_after_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
